// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the forwarding / load-use hazard controller:
// operand-select codes, FSM encodings and shadow-pipeline stage payloads.
package forward_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } ex_stage_t;

    // MEM and WB shadows only need to know who they write.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } wr_stage_t;

    // True when a stage will write a non-x0 register that matches idx.
    function automatic logic writes_reg(input wr_stage_t s, input logic [REG_W-1:0] idx);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == idx);
    endfunction

endpackage

// File: rtl/forward_ctrl_fwd_sel.sv
// Per-operand forwarding select: picks MEM over WB over the register file.
module fwd_sel
    import forward_ctrl_pkg::*;
(
    input  logic             ex_valid,
    input  logic [REG_W-1:0] src,
    input  wr_stage_t        mem,
    input  wr_stage_t        wb,
    output logic [FWD_W-1:0] sel_c
);

    always_comb begin
        sel_c = FWD_RF;
        if (ex_valid) begin
            if (writes_reg(mem, src)) begin
                sel_c = FWD_MEM;
            end else if (writes_reg(wb, src)) begin
                sel_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use stall controller tracking a shadow EX/MEM/WB pipeline.
// Define FWD_RF_BYPASS_EN to drive rf_byp_A/B from the WB shadow stage.
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [FWD_W-1:0] forward_A,
    output logic [FWD_W-1:0] forward_B,
    output logic             stall,
    output logic             rf_byp_A,
    output logic             rf_byp_B,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           state_q;
    state_t           state_d;
    ex_stage_t        ex_q;
    ex_stage_t        ex_d;
    wr_stage_t        mem_q;
    wr_stage_t        wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             hazard_c;
    logic             admit_c;

    // A load in EX whose destination is read by the instruction in ID.
    always_comb begin
        hazard_c = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid
                   && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard_c && !flush) begin
                    stall   = 1'b1;
                    state_d = LDSTALL;
                end
            end
            LDSTALL: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        admit_c = id_valid && !stall && !flush;
        ex_d    = '0;
        if (admit_c) begin
            ex_d.valid    = 1'b1;
            ex_d.rs1      = id_rs1;
            ex_d.rs2      = id_rs2;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
    end

    // Saturating count of stall cycles; never wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= wr_stage_t'{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    fwd_sel u_fwd_a (
        .ex_valid (ex_q.valid),
        .src      (ex_q.rs1),
        .mem      (mem_q),
        .wb       (wb_q),
        .sel_c    (forward_A)
    );

    fwd_sel u_fwd_b (
        .ex_valid (ex_q.valid),
        .src      (ex_q.rs2),
        .mem      (mem_q),
        .wb       (wb_q),
        .sel_c    (forward_B)
    );

`ifdef FWD_RF_BYPASS_EN
    assign rf_byp_A = writes_reg(wb_q, id_rs1);
    assign rf_byp_B = writes_reg(wb_q, id_rs2);
`else
    // Register file writes in the first half-cycle, so ID never needs a bypass.
    assign rf_byp_A = 1'b0;
    assign rf_byp_B = 1'b0;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed self-checking bench for forward_ctrl: a per-cycle instruction-history
// model plus hand-computed literal expectations at the key points of each scenario.
module tb_forward_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } ins_t;

`ifdef FWD_RF_BYPASS_EN
    localparam logic BYP_ON = 1'b1;
`else
    localparam logic BYP_ON = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic        byp_a;
    logic        byp_b;
    logic [15:0] stall_cnt;

    forward_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .forward_A   (fwd_a),
        .forward_B   (fwd_b),
        .stall       (stall),
        .rf_byp_A    (byp_a),
        .rf_byp_B    (byp_b),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   failures;
    logic done;
    logic sat_load;

    // Instruction constructors.
    function automatic ins_t i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return ins_t'{valid: 1'b1, rs1: rs1, rs2: rs2, rd: rd, regwrite: 1'b1, memread: 1'b0};
    endfunction
    function automatic ins_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return ins_t'{valid: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, regwrite: 1'b1, memread: 1'b1};
    endfunction
    function automatic ins_t i_nop();
        return ins_t'{valid: 1'b1, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, regwrite: 1'b1, memread: 1'b0};
    endfunction
    function automatic ins_t i_idle();
        return '0;
    endfunction

    // Model: the last three instructions that really entered EX (bubbles are idle).
    ins_t        m_ex;
    ins_t        m_mem;
    ins_t        m_wb;
    logic        m_prev_stall;
    logic [15:0] m_cnt;
    logic        m_st;

    function automatic ins_t cur_id();
        return ins_t'{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                      regwrite: id_regwrite, memread: id_memread};
    endfunction

    function automatic logic m_stall();
        return !m_prev_stall && !flush && id_valid && m_ex.valid && m_ex.memread
               && (m_ex.rd != 5'd0) && ((m_ex.rd == id_rs1) || (m_ex.rd == id_rs2));
    endfunction

    function automatic logic wrote(input ins_t s, input logic [4:0] r);
        return (r != 5'd0) && s.valid && s.regwrite && (s.rd == r);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (wrote(m_mem, r)) return 2'b10;
        if (wrote(m_wb, r))  return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_byp(input logic [4:0] r);
        return BYP_ON && wrote(m_wb, r);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ex         = '0;
            m_mem        = '0;
            m_wb         = '0;
            m_prev_stall = 1'b0;
            m_cnt        = 16'd0;
        end else begin
            m_st  = m_stall();
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (id_valid && !m_st && !flush) ? cur_id() : '0;
            if (sat_load) m_cnt = 16'hFFFF;
            else if (m_st && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
            m_prev_stall = m_st;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input ins_t i, input logic f);
        id_valid    = i.valid;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_rd       = i.rd;
        id_regwrite = i.regwrite;
        id_memread  = i.memread;
        flush       = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(i_idle(), 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        sat_load = 1'b0;
        rstn     = 1'b0;
        drive(i_idle(), 1'b0);

        fork
            // Per-cycle comparison against the model.
            begin
                while (!done) begin
                    @(negedge clk);
                    if (!rstn) begin
                        chk("rst_stall", 32'(stall), 32'd0);
                        chk("rst_fwd_a", 32'(fwd_a), 32'd0);
                        chk("rst_fwd_b", 32'(fwd_b), 32'd0);
                        chk("rst_cnt",   32'(stall_cnt), 32'd0);
                        chk("rst_byp",   32'({byp_a, byp_b}), 32'd0);
                    end else begin
                        chk("stall",     32'(stall), 32'(m_stall()));
                        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
                        if (m_ex.valid) begin
                            chk("fwd_a", 32'(fwd_a), 32'(m_fwd(m_ex.rs1)));
                            chk("fwd_b", 32'(fwd_b), 32'(m_fwd(m_ex.rs2)));
                        end
                        chk("byp_a", 32'(byp_a), 32'(m_byp(id_rs1)));
                        chk("byp_b", 32'(byp_b), 32'(m_byp(id_rs2)));
                    end
                end
            end

            // Directed scenarios.
            begin
                repeat (2) @(posedge clk);
                at_neg();
                chk("lit_reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
                chk("lit_reset_cnt", 32'(stall_cnt), 32'd0);
                @(posedge clk);
                #1;
                rstn = 1'b1;
                idle(2);

                // add x5 ; sub x6,x5,x3 -> MEM forward on A
                drive(i_add(5'd5, 5'd1, 5'd2), 1'b0); tick();
                drive(i_add(5'd6, 5'd5, 5'd3), 1'b0); tick();
                drive(i_idle(), 1'b0); at_neg();
                chk("lit_ex_mem_a", 32'(fwd_a), 32'h2);
                chk("lit_ex_mem_stall", 32'(stall), 32'd0);
                tick(); idle(3);

                // add x5 ; nop ; or x8,x1,x5 -> WB forward on B
                drive(i_add(5'd5, 5'd1, 5'd2), 1'b0); tick();
                drive(i_nop(), 1'b0); tick();
                drive(i_add(5'd8, 5'd1, 5'd5), 1'b0); tick();
                drive(i_idle(), 1'b0); at_neg();
                chk("lit_wb_b", 32'(fwd_b), 32'h1);
                chk("lit_wb_a", 32'(fwd_a), 32'h0);
                tick(); idle(3);

                // add x5 ; add x5 ; use x5 -> MEM beats WB
                drive(i_add(5'd5, 5'd1, 5'd2), 1'b0); tick();
                drive(i_add(5'd5, 5'd5, 5'd3), 1'b0); tick();
                drive(i_add(5'd9, 5'd4, 5'd5), 1'b0); tick();
                drive(i_idle(), 1'b0); at_neg();
                chk("lit_prio_b", 32'(fwd_b), 32'h2);
                tick(); idle(3);

                // WB-to-ID read (bypass only when enabled)
                drive(i_add(5'd5, 5'd1, 5'd2), 1'b0); tick();
                idle(2);
                drive(i_add(5'd11, 5'd5, 5'd6), 1'b0); at_neg();
                chk("lit_byp_a", 32'(byp_a), 32'(BYP_ON));
                tick(); idle(3);

                // lw x7 ; add x10,x1,x7 -> one stall cycle then WB forward
                drive(i_lw(5'd7, 5'd1), 1'b0); tick();
                drive(i_add(5'd10, 5'd1, 5'd7), 1'b0); at_neg();
                chk("lit_lu_stall", 32'(stall), 32'd1);
                chk("lit_lu_cnt0", 32'(stall_cnt), 32'd0);
                tick(); at_neg();
                chk("lit_lu_release", 32'(stall), 32'd0);
                chk("lit_lu_cnt1", 32'(stall_cnt), 32'd1);
                tick();
                drive(i_idle(), 1'b0); at_neg();
                chk("lit_lu_fwd_b", 32'(fwd_b), 32'h1);
                tick(); idle(3);

                // lw x7 ; use with flush -> no stall, bubble, count unchanged
                drive(i_lw(5'd7, 5'd1), 1'b0); tick();
                drive(i_add(5'd10, 5'd1, 5'd7), 1'b1); at_neg();
                chk("lit_fl_stall", 32'(stall), 32'd0);
                tick();
                drive(i_add(5'd12, 5'd7, 5'd0), 1'b0); at_neg();
                chk("lit_fl_cnt", 32'(stall_cnt), 32'd1);
                tick();
                drive(i_idle(), 1'b0); at_neg();
                chk("lit_fl_bubble_a", 32'(fwd_a), 32'h1);
                tick(); idle(3);

                // x0 writes and loads never forward or stall
                drive(i_add(5'd0, 5'd1, 5'd2), 1'b0); tick();
                drive(i_add(5'd3, 5'd0, 5'd0), 1'b0); tick();
                drive(i_idle(), 1'b0); at_neg();
                chk("lit_x0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
                tick();
                drive(i_lw(5'd0, 5'd1), 1'b0); tick();
                drive(i_add(5'd3, 5'd0, 5'd0), 1'b0); at_neg();
                chk("lit_x0_stall", 32'(stall), 32'd0);
                tick(); idle(3);

                // Preload the counter to all-ones, then one more stall
                at_neg(); #1;
                force dut.stall_cnt_q = 16'hFFFF;
                sat_load = 1'b1;
                @(posedge clk); #1;
                release dut.stall_cnt_q;
                sat_load = 1'b0;
                at_neg();
                chk("lit_sat_pre", 32'(stall_cnt), 32'hFFFF);
                tick();
                drive(i_lw(5'd7, 5'd1), 1'b0); tick();
                drive(i_add(5'd10, 5'd1, 5'd7), 1'b0); at_neg();
                chk("lit_sat_stall", 32'(stall), 32'd1);
                tick(); at_neg();
                chk("lit_sat_hold", 32'(stall_cnt), 32'hFFFF);
                tick(); idle(3);

                // Reset during LDSTALL
                drive(i_lw(5'd7, 5'd1), 1'b0); tick();
                drive(i_add(5'd10, 5'd1, 5'd7), 1'b0); tick();
                rstn = 1'b0;
                drive(i_idle(), 1'b0);
                #1;
                chk("lit_mrst_stall", 32'(stall), 32'd0);
                chk("lit_mrst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
                chk("lit_mrst_cnt", 32'(stall_cnt), 32'd0);
                chk("lit_mrst_byp", 32'({byp_a, byp_b}), 32'd0);
                @(posedge clk); #1;
                rstn = 1'b1;
                drive(i_add(5'd12, 5'd7, 5'd7), 1'b0); tick();
                drive(i_idle(), 1'b0); at_neg();
                chk("lit_post_fwd", 32'({fwd_a, fwd_b}), 32'd0);
                chk("lit_post_stall", 32'(stall), 32'd0);
                tick(); idle(3);
                done = 1'b1;
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
